mips_mc_control: RTL and testbench

Parametrised multicycle control unit for the MIPS datapath. It is a Moore state machine that decodes `Op` and sequences `PC`, `IR`, `MDR`, `A`, `B` and `ALUOut` through fetch, decode, execute, memory and writeback. Compared with the original control block it adds:
- a configurable memory latency, with hold states;
- `addi` support;
- an optional exception path (undefined opcode, ALU overflow) driving EPC/Cause.

It sits between `IR[31:26]` and the datapath enables.

---
 rtl/mips_mc_control.sv | 197 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states, addi support
// and an optional exception path (undefined opcode / ALU overflow).
module mips_mc_control #(
    parameter int STATE_W = 8,
    parameter int MEM_LAT = 1,
    parameter int EXC_EN  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         Op,
    input  logic               Overflow,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic               EPCWrite,
    output logic               CauseWrite,
    output logic               IntCause,
    output logic [STATE_W-1:0] StateOut
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_EXCEPT   = 4'd13
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    localparam logic       EXC_ON = (EXC_EN != 0);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       cause_reg, cause_next;

    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_RESET;
            cnt_reg   <= 4'd0;
            cause_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_RESET:    state_next = S_FETCH;
            S_FETCH:    if (cnt_reg == 4'd0) state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    6'h00:        state_next = S_EXECUTE;
                    6'h23, 6'h2B: state_next = S_MEMADDR;
                    6'h04:        state_next = S_BRANCH;
                    6'h02:        state_next = S_JUMP;
                    6'h08:        state_next = S_ADDI_EX;
                    default: begin
                        if (EXC_ON) begin
                            state_next = S_EXCEPT;
                            cause_next = 1'b0;
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                endcase
            end
            // IR is stable, so Op is re-examined to split lw from sw.
            S_MEMADDR:  state_next = (Op == 6'h2B) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (cnt_reg == 4'd0) state_next = S_MEMWB;
            S_MEMWRITE: if (cnt_reg == 4'd0) state_next = S_FETCH;
            S_EXECUTE, S_ADDI_EX: begin
                if (EXC_ON && Overflow) begin
                    state_next = S_EXCEPT;
                    cause_next = 1'b1;
                end else begin
                    state_next = (state_reg == S_EXECUTE) ? S_RTYPE_WB : S_ADDI_WB;
                end
            end
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB,
            S_BRANCH, S_JUMP, S_EXCEPT: state_next = S_FETCH;
            default:    state_next = S_RESET;
        endcase

        // Wait counter reloads on entry to a memory state, counts down while inside.
        if (is_wait(state_next) && (state_next != state_reg))
            cnt_next = LAT_M1;
        else if (is_wait(state_reg) && (cnt_reg != 4'd0))
            cnt_next = cnt_reg - 4'd1;
        else
            cnt_next = cnt_reg;
    end

    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        IntCause    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = (cnt_reg == 4'd0);
                PCWrite = (cnt_reg == 4'd0);
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTYPE_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_EXCEPT: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                IntCause   = cause_reg;
            end
            default: ;
        endcase
    end

    assign StateOut = STATE_W'(state_reg);

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: three configurations (latency / exception enable),
// each run against an instruction-level model that expands opcodes into expected cycles.
module tb_mips_mc_control;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       epc_write;
        logic       cause_write;
        logic       int_cause;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } step_t;

    localparam int NCFG = 3;

    logic       clk = 1'b0;
    logic       rst_n_a [NCFG];
    logic [5:0] op_a    [NCFG];
    logic       ovf_a   [NCFG];
    ctl_t       got_a   [NCFG];
    logic [7:0] st_a    [NCFG];

    int checks = 0;
    int errors = 0;
    step_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int LAT = (gi == 1) ? 3 : ((gi == 2) ? 2 : 1);
        localparam int EXC = (gi == 2) ? 0 : 1;
        logic       pcwc, pcw, iord, mrd, mwr, m2r, irw, asa, rgw, rgd, epcw, cw, ic;
        logic [1:0] pcs, aop, asb;
        mips_mc_control #(.STATE_W(8), .MEM_LAT(LAT), .EXC_EN(EXC)) dut (
            .clk(clk), .reset_n(rst_n_a[gi]), .Op(op_a[gi]), .Overflow(ovf_a[gi]),
            .PCWriteCond(pcwc), .PCWrite(pcw), .IorD(iord), .MemRead(mrd),
            .MemWrite(mwr), .MemtoReg(m2r), .IRWrite(irw), .ALUSrcA(asa),
            .RegWrite(rgw), .RegDst(rgd), .PCSource(pcs), .ALUOp(aop),
            .ALUSrcB(asb), .EPCWrite(epcw), .CauseWrite(cw), .IntCause(ic),
            .StateOut(st_a[gi])
        );
        assign got_a[gi] = {pcwc, pcw, iord, mrd, mwr, m2r, irw, asa, rgw, rgd,
                            pcs, aop, asb, epcw, cw, ic};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word each state must present, straight from the state table.
    function automatic ctl_t ctl_of(input int st, input bit last, input bit cause);
        ctl_t c;
        c = '0;
        case (st)
            1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = last; c.pc_write = last; end
            2:  c.alu_src_b = 2'b11;
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4:  begin c.mem_read = 1; c.ior_d = 1; end
            5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            6:  begin c.mem_write = 1; c.ior_d = 1; end
            7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            8:  begin c.reg_dst = 1; c.reg_write = 1; end
            9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            10: begin c.pc_write = 1; c.pc_source = 2'b10; end
            11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            12: c.reg_write = 1;
            13: begin
                c.pc_write = 1; c.pc_source = 2'b11; c.epc_write = 1;
                c.cause_write = 1; c.int_cause = cause;
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic push(input int st, input bit last, input bit cause);
        exp_q.push_back({4'(st), ctl_of(st, last, cause)});
    endtask

    // Expand one instruction into the cycle-by-cycle state sequence it should take.
    task automatic build(input int lat, input int exc, input logic [5:0] op, input bit ovf);
        exp_q.delete();
        for (int i = 0; i < lat; i++) push(1, i == lat - 1, 0);
        push(2, 0, 0);
        case (op)
            6'h00: begin push(7, 0, 0); if (exc != 0 && ovf) push(13, 0, 1); else push(8, 0, 0); end
            6'h23: begin push(3, 0, 0); for (int i = 0; i < lat; i++) push(4, 0, 0); push(5, 0, 0); end
            6'h2B: begin push(3, 0, 0); for (int i = 0; i < lat; i++) push(6, 0, 0); end
            6'h04: push(9, 0, 0);
            6'h02: push(10, 0, 0);
            6'h08: begin push(11, 0, 0); if (exc != 0 && ovf) push(13, 0, 1); else push(12, 0, 0); end
            default: if (exc != 0) push(13, 0, 0);
        endcase
    endtask

    task automatic check_reset(input int idx);
        chk($sformatf("c%0d reset_state", idx), 32'(st_a[idx]), 32'd0);
        chk($sformatf("c%0d reset_ctl", idx), 32'(got_a[idx]), 32'd0);
    endtask

    task automatic run_cfg(input int idx, input int lat, input int exc);
        logic [5:0] dir_op [8];
        bit         dir_ovf[8];
        logic [5:0] opv;
        bit         ovv;
        bit         do_rst;
        int         st;
        int         rst_k;
        dir_op  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h23};
        dir_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst_k   = (lat >= 2) ? lat + 3 : lat + 2;
        rst_n_a[idx] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset(idx);
        rst_n_a[idx] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i < 8) begin
                opv = dir_op[i];
                ovv = dir_ovf[i];
            end else begin
                case ($urandom_range(0, 7))
                    0: opv = 6'h00;  1: opv = 6'h23;  2: opv = 6'h2B;  3: opv = 6'h04;
                    4: opv = 6'h02;  5: opv = 6'h08;  6: opv = 6'h3F;
                    default: opv = 6'($urandom_range(9, 34));
                endcase
                ovv = 1'($urandom);
            end
            build(lat, exc, opv, ovv);
            $display("cfg %0d lat %0d exc %0d instr %0d op=%h ovf=%0b cycles=%0d",
                     idx, lat, exc, i, opv, ovv, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                chk($sformatf("c%0d i%0d k%0d state", idx, i, k), 32'(st_a[idx]), 32'(exp_q[k].st));
                chk($sformatf("c%0d i%0d k%0d ctl", idx, i, k), 32'(got_a[idx]), 32'(exp_q[k].c));
                st = int'(exp_q[k].st);
                // Only DECODE/MEMADDR/EXECUTE/ADDI_EX see real inputs; elsewhere drive noise.
                if (st == 2 || st == 3 || st == 7 || st == 11) begin
                    op_a[idx]  = opv;
                    ovf_a[idx] = ovv;
                end else begin
                    op_a[idx]  = 6'($urandom);
                    ovf_a[idx] = 1'($urandom);
                end
                do_rst = (i == 7 && k == rst_k) || (i > 7 && $urandom_range(0, 49) == 0);
                if (do_rst) begin
                    rst_n_a[idx] = 1'b0;
                    @(negedge clk);
                    check_reset(idx);
                    rst_n_a[idx] = 1'b1;
                    break;
                end
            end
        end
        rst_n_a[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            rst_n_a[i] = 1'b0;
            op_a[i]    = 6'h00;
            ovf_a[i]   = 1'b0;
        end
        run_cfg(0, 1, 1);
        run_cfg(1, 3, 1);
        run_cfg(2, 2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
